// File: rtl/alu_matrix_top.sv
// alu_matrix_top: 3x3 matrix ALU with 32-bit elements.
// Holds operand matrices A, B and result matrix R. A 6-bit command word
// selects one of: load an A element, load a B element, run a whole-matrix
// operation into R, or read one R element onto eleOut. One command per clock.
module alu_matrix_top #(
    parameter int DW = 32,
    parameter int N  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    sel,
    input  logic [DW-1:0] eleIn,
    output logic [DW-1:0] eleOut
);

    localparam int NE = N * N;

    // Command classes carried in sel[5:4]
    localparam logic [1:0] CLS_LOAD_A = 2'b00;
    localparam logic [1:0] CLS_LOAD_B = 2'b01;
    localparam logic [1:0] CLS_EXEC   = 2'b10;
    localparam logic [1:0] CLS_READ   = 2'b11;

    // Matrix storage is plain registers: EXEC needs all elements of A and B
    // at once, so a RAM with a single read port would not serve.
    logic [DW-1:0] r_a [NE];
    logic [DW-1:0] r_b [NE];
    logic [DW-1:0] r_r [NE];
    logic [DW-1:0] r_ele_out;

    logic [1:0]    w_cls;
    logic [3:0]    w_idx;
    logic [DW-1:0] w_exec [NE];
    logic [DW-1:0] w_rd;

    assign w_cls = sel[5:4];
    assign w_idx = sel[3:0];

    // One result lane per element of R; each lane knows its own row/column
    // so transpose and matrix product are pure wiring plus arithmetic.
    for (genvar gi = 0; gi < NE; gi++) begin : g_lane
        localparam int ROW = gi / N;
        localparam int COL = gi % N;

        logic [DW-1:0] w_dot;

        // Compute the candidate R element for the opcode in sel[3:0]
        always_comb begin
            w_dot = '0;
            for (int k = 0; k < N; k++) begin
                w_dot = w_dot + r_a[ROW*N + k] * r_b[k*N + COL];
            end
            case (w_idx)
                4'd0:    w_exec[gi] = r_a[gi] + r_b[gi];
                4'd1:    w_exec[gi] = r_a[gi] - r_b[gi];
                4'd2:    w_exec[gi] = r_a[gi] * r_b[gi];
                4'd3:    w_exec[gi] = w_dot;
                4'd4:    w_exec[gi] = r_a[COL*N + ROW];
                4'd5:    w_exec[gi] = eleIn * r_a[gi];
                4'd6:    w_exec[gi] = '0;
                default: w_exec[gi] = r_r[gi];   // unused opcodes leave R alone
            endcase
        end
    end

    // Select the R element addressed by a READ; indices past 8 read as zero
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NE; i++) begin
            if (w_idx == 4'(i)) begin
                w_rd = r_r[i];
            end
        end
    end

    // Matrix state and read register; reset wins over any command
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NE; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_r[i] <= '0;
            end
            r_ele_out <= '0;
        end else begin
            case (w_cls)
                CLS_LOAD_A: begin
                    for (int i = 0; i < NE; i++) begin
                        if (w_idx == 4'(i)) r_a[i] <= eleIn;
                    end
                end
                CLS_LOAD_B: begin
                    for (int i = 0; i < NE; i++) begin
                        if (w_idx == 4'(i)) r_b[i] <= eleIn;
                    end
                end
                CLS_EXEC: begin
                    for (int i = 0; i < NE; i++) begin
                        r_r[i] <= w_exec[i];
                    end
                end
                CLS_READ: begin
                    r_ele_out <= w_rd;
                end
            endcase
        end
    end

    assign eleOut = r_ele_out;

endmodule

// File: tb/tb_alu_matrix_top.sv
// Bench for alu_matrix_top: directed steps from the test plan followed by a
// random command stream, all checked against a matrix-level reference model.
module tb_alu_matrix_top;

    logic        clk;
    logic        reset;
    logic [5:0]  sel;
    logic [31:0] eleIn;
    logic [31:0] eleOut;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_a [9];
    logic [31:0] m_b [9];
    logic [31:0] m_r [9];
    logic [31:0] m_out;

    alu_matrix_top #(.DW(32), .N(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .eleIn  (eleIn),
        .eleOut (eleOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: eleOut=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Whole-matrix operation written with row/column loops
    task automatic model_exec(input logic [3:0] op, input logic [31:0] s);
        logic [31:0] t [9];
        logic [31:0] acc;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                case (op)
                    4'd0: t[i*3+j] = m_a[i*3+j] + m_b[i*3+j];
                    4'd1: t[i*3+j] = m_a[i*3+j] - m_b[i*3+j];
                    4'd2: t[i*3+j] = m_a[i*3+j] * m_b[i*3+j];
                    4'd3: begin
                        acc = 0;
                        for (int k = 0; k < 3; k++) acc = acc + m_a[i*3+k] * m_b[k*3+j];
                        t[i*3+j] = acc;
                    end
                    4'd4: t[i*3+j] = m_a[j*3+i];
                    4'd5: t[i*3+j] = s * m_a[i*3+j];
                    4'd6: t[i*3+j] = 0;
                    default: t[i*3+j] = m_r[i*3+j];
                endcase
            end
        end
        for (int i = 0; i < 9; i++) m_r[i] = t[i];
    endtask

    task automatic model_apply(input logic [5:0] s, input logic [31:0] d, input logic rst_n);
        int idx;
        idx = int'(s[3:0]);
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                m_a[i] = 0; m_b[i] = 0; m_r[i] = 0;
            end
            m_out = 0;
        end else begin
            case (s[5:4])
                2'b00: if (idx < 9) m_a[idx] = d;
                2'b01: if (idx < 9) m_b[idx] = d;
                2'b10: model_exec(s[3:0], d);
                2'b11: m_out = (idx < 9) ? m_r[idx] : 32'd0;
            endcase
        end
    endtask

    // Drive one command for one clock, then compare eleOut with the model
    task automatic cmd(input logic [5:0] s, input logic [31:0] d, input logic rst_n);
        @(negedge clk);
        sel   = s;
        eleIn = d;
        reset = rst_n;
        @(posedge clk);
        #1;
        model_apply(s, d, rst_n);
        $display("cmd sel=%02h eleIn=%08h reset=%0b -> eleOut=%08h", s, d, rst_n, eleOut);
        check("model", eleOut, m_out);
    endtask

    task automatic load_a(input int i, input logic [31:0] v);
        cmd({2'b00, 4'(i)}, v, 1'b1);
    endtask

    task automatic load_b(input int i, input logic [31:0] v);
        cmd({2'b01, 4'(i)}, v, 1'b1);
    endtask

    task automatic exec_op(input int op, input logic [31:0] s);
        cmd({2'b10, 4'(op)}, s, 1'b1);
    endtask

    task automatic read_exp(input int i, input logic [31:0] exp, input string tag);
        cmd({2'b11, 4'(i)}, 32'd0, 1'b1);
        check(tag, eleOut, exp);
    endtask

    initial begin
        reset = 1'b0;
        sel   = 6'b110000;
        eleIn = 32'd0;

        // Reset held two cycles with a READ on sel
        cmd(6'b110000, 32'd0, 1'b0);
        cmd(6'b110000, 32'd0, 1'b0);
        check("reset_out", eleOut, 32'd0);
        for (int i = 0; i < 9; i++) read_exp(i, 32'd0, "reset_r");

        // Load / add / read
        for (int i = 0; i < 9; i++) load_a(i, 32'(i + 1));
        for (int i = 0; i < 9; i++) load_b(i, 32'd10);
        exec_op(0, 0);
        read_exp(4, 32'd15, "add_r4");
        read_exp(8, 32'd19, "add_r8");
        exec_op(2, 0);
        read_exp(7, 32'd80, "emul_r7");
        exec_op(9, 0);
        read_exp(7, 32'd80, "noop_r7");

        // Matrix multiply by identity, then by itself
        for (int i = 0; i < 9; i++) load_b(i, (i % 4 == 0) ? 32'd1 : 32'd0);
        exec_op(3, 0);
        read_exp(5, 32'd6, "mmul_id_r5");
        for (int i = 0; i < 9; i++) load_b(i, 32'(i + 1));
        exec_op(3, 0);
        read_exp(0, 32'd30, "mmul_sq_r0");
        read_exp(8, 32'd150, "mmul_sq_r8");

        // Transpose and scalar multiply
        exec_op(4, 0);
        read_exp(1, 32'd4, "trans_r1");
        exec_op(5, 32'd3);
        read_exp(2, 32'd9, "scal_r2");
        exec_op(6, 0);
        read_exp(2, 32'd0, "zero_r2");

        // Wrap-around in add and subtract
        load_a(0, 32'hFFFF_FFFF);
        load_b(0, 32'd1);
        exec_op(0, 0);
        read_exp(0, 32'd0, "wrap_add");
        load_a(0, 32'd0);
        exec_op(1, 0);
        read_exp(0, 32'hFFFF_FFFF, "wrap_sub");

        // Out-of-range loads leave A/B unchanged; out-of-range read gives 0
        for (int i = 0; i < 9; i++) load_a(i, 32'(i + 1));
        for (int i = 0; i < 9; i++) load_b(i, 32'd10);
        cmd(6'b011111, 32'd30, 1'b1);
        cmd(6'b001001, 32'd77, 1'b1);
        exec_op(0, 0);
        for (int i = 0; i < 9; i++) read_exp(i, 32'(i + 11), "oor_load");
        read_exp(12, 32'd0, "oor_read");

        // Reset in the cycle right after an EXEC clears R
        exec_op(2, 0);
        cmd(6'b100000, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) read_exp(i, 32'd0, "midrst_r");

        // Random command stream against the model
        for (int n = 0; n < 400; n++) begin
            logic [5:0]  s;
            logic [31:0] d;
            s = 6'($urandom_range(0, 63));
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            cmd(s, d, ($urandom_range(0, 99) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
